de2_switch_debouncer: RTL and testbench
=======================================

# de2_switch_debouncer

Synchronises and debounces the DE2 slide-switch bank before it enters the toggle-switch PIO, so the PIO's edge-capture logic sees exactly one clean transition per physical flip. It sits directly upstream of the PIO: board pins drive `sw_in`, and `sw_out` drives the PIO's `in_port`. Each bit goes through a two-flop synchroniser and then a per-bit stability counter. A single shared prescaler sets the sampling time base for all bits.

## Interface
- `WIDTH`, 18: number of switch bits.
- `TICK_DIV`, 50000: clk cycles per sampling tick (1 ms at 50 MHz); legal range ≥ 2.
- `STABLE_TICKS`, 10: consecutive ticks of unbroken disagreement required to accept a new level; legal range ≥ 1.

- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `sw_in` in WIDTH: raw asynchronous switch pins.
- `sw_out` out WIDTH: debounced level, registered.
- `toggle_pulse` out WIDTH: one-cycle pulse per accepted change. Present only with the macro described under Configuration.

## Operation
- **Synchroniser.** `s1 <= sw_in`, then `s2 <= s1`. All downstream logic uses `s2` only.
- **Prescaler.** `div_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is high combinationally for the single cycle in which `div_cnt == TICK_DIV-1`.
- **Per-bit state.** Each bit i has `cnt_i` of width clog2(STABLE_TICKS+1) and `mismatch_i = s2[i] ^ sw_out[i]`.
- **Counter rules, per clock edge:**
  - `!mismatch_i`: clear `cnt_i`. Any bounce back to the accepted level restarts the count.
  - `mismatch_i && tick && cnt_i == STABLE_TICKS-1`: set `sw_out[i] <= s2[i]` and clear `cnt_i`.
  - `mismatch_i && tick` otherwise: increment `cnt_i`.
  - `mismatch_i && !tick`: hold `cnt_i`.
- **Counter bound.** `cnt_i` never exceeds STABLE_TICKS-1, so no saturation logic is needed.
- **Bit independence.** Bits are independent. Several bits may update on the same edge.
- **No new-value reset.** A new value on `s2` during a count does not restart the count if it still disagrees with `sw_out`. For a 1-bit signal, disagreement means one specific value, so this case is consistent.

## Timing
- **Reset values.** `s1`, `s2`, `sw_out`, `toggle_pulse`, `div_cnt` and every `cnt_i` are 0.
- **Synchroniser latency.** 2 cycles from `sw_in` to `s2`.
- **Acceptance latency.** Measured from the edge where `mismatch_i` first rises: `sw_out` changes on the STABLE_TICKS-th subsequent tick edge. The bound is ((STABLE_TICKS-1)·TICK_DIV + 1) to (STABLE_TICKS·TICK_DIV) cycles, depending on prescaler phase.
- **Pulse timing.** `toggle_pulse[i]` is high for exactly the cycle after `sw_out[i]` changes. It is registered and aligned with the new `sw_out`.
- **Reset mid-count.** Asynchronous reset aborts the count and forces `sw_out` to 0 immediately. After release, any switch already high is accepted through a normal full debounce interval; this produces one rising edge at the PIO.
- **Glitch on the tick cycle.** If `mismatch_i` drops on the same edge as a tick, the clear wins. The counter does not increment.

## Configuration
- **`DE2_DEBOUNCE_PULSE_EN` defined:**
  - The `toggle_pulse` port exists.
  - Per bit, `toggle_pulse[i] <= (mismatch_i && tick && cnt_i == STABLE_TICKS-1)`.
- **Undefined:**
  - The port and its register are absent.
  - All other behaviour is identical.

## Structure
- **Package `de2_debounce_pkg`:**
  - Default constants `DEB_WIDTH_DEF=18`, `DEB_TICK_DIV_DEF=50000` and `DEB_STABLE_TICKS_DEF=10`.
  - Counter-width function `deb_cnt_w(stable_ticks)`.
- **Sub-module `de2_debounce_bit`.** Holds the synchroniser pair, `cnt_i` and `sw_out[i]` for one bit. Its inputs are `tick` and `reset`. The top generates WIDTH instances and owns the shared prescaler.

## Test plan
All scenarios use WIDTH=18, TICK_DIV=4, STABLE_TICKS=3.
- **Reset.** Assert `reset` with `sw_in=18'h3FFFF` → `sw_out=0` and `toggle_pulse=0` immediately. After release, `sw_out=18'h3FFFF` appears within 9..12 cycles + 2 of `s2` mismatch, with one `toggle_pulse=18'h3FFFF` cycle.
- **Clean step.** Step bit 0 from 0 to 1 and hold → `sw_out[0]=1` exactly on the 3rd tick edge after `s2[0]` rises. A single `toggle_pulse[0]` pulse follows; other bits are unchanged.
- **Bounce.** Toggle bit 5 every 3 cycles for 30 cycles, then hold 1 → no `sw_out` change during bouncing. `sw_out[5]=1` arrives 3 full ticks after the final stable edge.
- **Glitch on tick.** `s2` mismatch drops precisely on a tick cycle → `cnt` reads 0 the next cycle, with no increment.
- **Simultaneous updates.** Bits 3 and 17 change in the same cycle → both update on the same edge, and `toggle_pulse=18'h20008` for one cycle.
- **Reset mid-count.** Pulse `reset` after 2 ticks of mismatch → `sw_out` stays 0 and a full 3-tick count restarts after release.

Source files
------------

// File: rtl/de2_switch_debouncer_pkg.sv
// Shared constants and helpers for the DE2 slide-switch debouncer.
// Optional toggle_pulse output is enabled by DE2_DEBOUNCE_PULSE_EN.
package de2_debounce_pkg;

   localparam int DEB_WIDTH_DEF        = 18;
   localparam int DEB_TICK_DIV_DEF     = 50000;
   localparam int DEB_STABLE_TICKS_DEF = 10;

   function automatic int deb_cnt_w(input int stable_ticks);
      return $clog2(stable_ticks + 1);
   endfunction

endpackage

// File: rtl/de2_switch_debouncer_if.sv
// Switch bus between board pins / PIO and the debouncer.
// toggle_pulse is present only with DE2_DEBOUNCE_PULSE_EN.
interface de2_switch_debouncer_if
   import de2_debounce_pkg::*;
#(
   parameter int WIDTH = DEB_WIDTH_DEF
);

   logic [WIDTH-1:0] sw_in;
   logic [WIDTH-1:0] sw_out;
`ifdef DE2_DEBOUNCE_PULSE_EN
   logic [WIDTH-1:0] toggle_pulse;

   modport master (
      output sw_in,
      input  sw_out,
      input  toggle_pulse
   );

   modport slave (
      input  sw_in,
      output sw_out,
      output toggle_pulse
   );
`else
   modport master (
      output sw_in,
      input  sw_out
   );

   modport slave (
      input  sw_in,
      output sw_out
   );
`endif

endinterface

// File: rtl/de2_switch_debouncer_bit.sv
// One switch bit: 2-flop synchroniser plus stability counter.
// Registered toggle_pulse exists only with DE2_DEBOUNCE_PULSE_EN.
module de2_debounce_bit
   import de2_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_in,
   input  logic tick,
`ifdef DE2_DEBOUNCE_PULSE_EN
   output logic toggle_pulse,
`endif
   output logic sw_out
);

   localparam int CW = deb_cnt_w(STABLE_TICKS);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          mismatch;
   logic          accept;

   assign mismatch = s2 ^ sw_out;
   assign accept   = mismatch && tick && (cnt == LAST);

   // Any return to the accepted level clears the count, even on a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         sw_out <= 1'b0;
`ifdef DE2_DEBOUNCE_PULSE_EN
         toggle_pulse <= 1'b0;
`endif
      end else begin
         s1 <= sw_in;
         s2 <= s1;
         if (!mismatch) begin
            cnt <= '0;
         end else if (accept) begin
            sw_out <= s2;
            cnt    <= '0;
         end else if (tick) begin
            cnt <= cnt + 1'b1;
         end
`ifdef DE2_DEBOUNCE_PULSE_EN
         toggle_pulse <= accept;
`endif
      end
   end

endmodule

// File: rtl/de2_switch_debouncer.sv
// Debounces the DE2 slide switches ahead of the toggle-switch PIO.
// Define DE2_DEBOUNCE_PULSE_EN to add the per-bit toggle_pulse output.
module de2_switch_debouncer
   import de2_debounce_pkg::*;
#(
   parameter int WIDTH        = DEB_WIDTH_DEF,
   parameter int TICK_DIV     = DEB_TICK_DIV_DEF,
   parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEF
) (
   input logic                   clk,
   input logic                   reset,
   de2_switch_debouncer_if.slave bus
);

   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic [DW-1:0]    div_cnt;
   logic             tick;
   logic [WIDTH-1:0] sw_out_w;
`ifdef DE2_DEBOUNCE_PULSE_EN
   logic [WIDTH-1:0] pulse_w;
`endif

   assign tick = (div_cnt == DIV_LAST);

   // One prescaler shared by every bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      de2_debounce_bit #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_bit (
         .clk         (clk),
         .reset       (reset),
         .sw_in       (bus.sw_in[i]),
         .tick        (tick),
`ifdef DE2_DEBOUNCE_PULSE_EN
         .toggle_pulse(pulse_w[i]),
`endif
         .sw_out      (sw_out_w[i])
      );
   end

   assign bus.sw_out = sw_out_w;
`ifdef DE2_DEBOUNCE_PULSE_EN
   assign bus.toggle_pulse = pulse_w;
`endif

endmodule

// File: tb/tb_de2_switch_debouncer.sv
// Directed bench for de2_switch_debouncer (WIDTH=18, TICK_DIV=4, STABLE_TICKS=3).
// Pulse checks are compiled in with DE2_DEBOUNCE_PULSE_EN.
module tb_de2_switch_debouncer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_err = 0;
   int   n_chk = 0;
   int   edge_n;

   de2_switch_debouncer_if #(.WIDTH(18)) bus ();

   de2_switch_debouncer #(
      .WIDTH       (18),
      .TICK_DIV    (4),
      .STABLE_TICKS(3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Edges since reset release; ticks land on edges 4, 8, 12, ...
   always @(posedge clk or posedge reset) begin
      if (reset) edge_n <= 0;
      else       edge_n <= edge_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_to(input int n);
      while (edge_n < n) @(negedge clk);
   endtask

   task automatic chk_pulse(input string tag, input logic [17:0] exp);
`ifdef DE2_DEBOUNCE_PULSE_EN
      check(tag, 32'(bus.toggle_pulse), 32'(exp));
`endif
   endtask

   task automatic do_reset(input logic [17:0] val);
      reset      = 1'b1;
      bus.sw_in  = val;
      #1;
      check("rst_async_out", 32'(bus.sw_out), 32'h0);
      chk_pulse("rst_async_pulse", 18'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // Reset with all switches high
      bus.sw_in = 18'h3FFFF;
      #1;
      check("rst_out", 32'(bus.sw_out), 32'h0);
      chk_pulse("rst_pulse", 18'h0);
      @(negedge clk);
      @(negedge clk);
      check("rst_hold", 32'(bus.sw_out), 32'h0);
      reset = 1'b0;
      wait_to(11);
      check("rst_pre", 32'(bus.sw_out), 32'h0);
      wait_to(12);
      check("rst_acc", 32'(bus.sw_out), 32'h3FFFF);
      chk_pulse("rst_acc_pulse", 18'h3FFFF);
      wait_to(13);
      chk_pulse("rst_pulse_end", 18'h0);

      // Clean step on bit 0 (also checks async clear of ones)
      do_reset(18'h0);
      wait_to(5);
      bus.sw_in[0] = 1'b1;
      wait_to(15);
      check("step_pre", 32'(bus.sw_out), 32'h0);
      wait_to(16);
      check("step_acc", 32'(bus.sw_out), 32'h1);
      chk_pulse("step_pulse", 18'h1);
      wait_to(17);
      check("step_hold", 32'(bus.sw_out), 32'h1);
      chk_pulse("step_pulse_end", 18'h0);

      // Bounce on bit 5
      do_reset(18'h0);
      for (int k = 0; k < 10; k++) begin
         wait_to(4 + 3 * k);
         check("bounce_hold", 32'(bus.sw_out), 32'h0);
         bus.sw_in[5] = ~bus.sw_in[5];
      end
      wait_to(34);
      check("bounce_end", 32'(bus.sw_out), 32'h0);
      bus.sw_in[5] = 1'b1;
      wait_to(47);
      check("bounce_pre", 32'(bus.sw_out), 32'h0);
      wait_to(48);
      check("bounce_acc", 32'(bus.sw_out), 32'h20);
      chk_pulse("bounce_pulse", 18'h20);

      // One-cycle drop of s2[1] on the third tick
      do_reset(18'h0);
      wait_to(1);
      bus.sw_in[1] = 1'b1;
      wait_to(9);
      bus.sw_in[1] = 1'b0;
      wait_to(10);
      bus.sw_in[1] = 1'b1;
      wait_to(12);
      check("glitch_tick", 32'(bus.sw_out), 32'h0);
      wait_to(16);
      check("glitch_t16", 32'(bus.sw_out), 32'h0);
      wait_to(23);
      check("glitch_pre", 32'(bus.sw_out), 32'h0);
      wait_to(24);
      check("glitch_acc", 32'(bus.sw_out), 32'h2);
      chk_pulse("glitch_pulse", 18'h2);

      // Bits 3 and 17 together
      do_reset(18'h0);
      wait_to(2);
      bus.sw_in = 18'h20008;
      wait_to(15);
      check("simul_pre", 32'(bus.sw_out), 32'h0);
      wait_to(16);
      check("simul_acc", 32'(bus.sw_out), 32'h20008);
      chk_pulse("simul_pulse", 18'h20008);
      wait_to(17);
      chk_pulse("simul_pulse_end", 18'h0);

      // Reset after two counted ticks
      do_reset(18'h0);
      wait_to(1);
      bus.sw_in[0] = 1'b1;
      wait_to(9);
      check("midrst_pre", 32'(bus.sw_out), 32'h0);
      do_reset(18'h1);
      wait_to(11);
      check("midrst_wait", 32'(bus.sw_out), 32'h0);
      wait_to(12);
      check("midrst_acc", 32'(bus.sw_out), 32'h1);
      chk_pulse("midrst_pulse", 18'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
